jt900h_useq: RTL
================

JT900H_USEQ -- requirements
Module: jt900h_useq

Interface
REQ-001 SHALL have parameter UAW, default 14, microaddress width (UAW >= OPW+6).
REQ-002 SHALL have parameter OPW, default 8, opcode (md) width.
REQ-003 SHALL have parameter STKD, default 4, return-stack depth (power of two, 2..16).
REQ-004 SHALL have parameter LCW, default 8, loop-counter width.
REQ-005 SHALL have parameter RST_UA, default 0, microaddress loaded at reset.
REQ-006 clk  in  1  clock; one clock for the whole block.
REQ-007 rst  in  1  reset; asynchronous, active-high.
REQ-008 cen  in  1  clock enable; no state changes while low.
REQ-009 still  in  1  stall (divider/memory busy); freezes all state while high.
REQ-010 md  in  OPW  current opcode byte; bits [3:0] also select the cc condition.
REQ-011 flags  in  8  S,Z,-,H,-,V,N,C at bits 7,6,4,2,1,0.
REQ-012 zu  in  1  ALU zero.
REQ-013 ni  in  1  next-instruction dispatch.
REQ-014 nxgr  in  2  dispatch group.
REQ-015 jsr_en  in  1  microsubroutine call request.
REQ-016 jsr_cnd  in  2  call condition: 0 always, 1 only if cc, 2 only if !cc, 3 only if !zu.
REQ-017 jsr_ua  in  UAW  call target.
REQ-018 ret  in  1  return request.
REQ-019 lp_ld  in  1  load loop counter and mark loop start.
REQ-020 lp_cnt  in  LCW  iteration count.
REQ-021 lp_end  in  1  loop-end marker.
REQ-022 uaddr  out  UAW  current microaddress (registered).
REQ-023 cc  out  1  condition result (combinational).
REQ-024 stk_lvl  out  $clog2(STKD)+1  return-stack occupancy.
REQ-025 lp_busy  out  1  loop counter non-zero.
REQ-026 ovf  out  1  sticky stack-overflow error.
REQ-027 unf  out  1  sticky stack-underflow error.

Function
REQ-028 cc SHALL decode md[3:0] as: 0 F; 1 S^V; 2 Z|(S^V); 3 Z|C; 4 V; 5 S; 6 Z; 7 C; 8 T; 9..15 the complements of 1..7.
REQ-029 A state update SHALL occur only on a rising clk edge with cen=1 and still=0.
REQ-030 Default next uaddr SHALL be {uaddr[UAW-1:4], uaddr[3:0]+1}; the low nibble wraps 15->0 with no carry into the upper bits.
REQ-031 A call SHALL be taken when jsr_en=1 and its jsr_cnd condition holds.
REQ-032 On a taken call: push {uaddr[UAW-1:4], uaddr[3:0]+1}, set uaddr=jsr_ua, increment stk_lvl.
REQ-033 On ret with stk_lvl>0: uaddr=top of stack, decrement stk_lvl.
REQ-034 Taken call and ret in the same cycle SHALL act as a tail call: uaddr=jsr_ua, stack and stk_lvl unchanged.
REQ-035 Push at stk_lvl=STKD SHALL set ovf, perform the jump, and leave the stack unchanged.
REQ-036 ret at stk_lvl=0 SHALL set unf and take the default next uaddr.
REQ-037 lp_ld SHALL load the counter with lp_cnt and save the loop start as uaddr[3:0]+1.
REQ-038 lp_end with counter>1 SHALL decrement the counter and set uaddr[3:0]=loop start.
REQ-039 lp_end with counter<=1 SHALL clear the counter and fall through.
REQ-040 lp_ld with lp_cnt=0 SHALL behave as a single pass.
REQ-041 ni SHALL set uaddr={zero-pad, nxgr, md, 4'd0}, clear the counter, and leave the stack unchanged.
REQ-042 Priority SHALL be: taken call / tail call > ret > lp_end loop-back > ni > default.
REQ-043 lp_ld SHALL be honoured in the same cycle as any of the events in REQ-042.
REQ-044 ovf and unf SHALL clear only on reset.

Reset
REQ-045 Reset SHALL set uaddr=RST_UA and stk_lvl=0, clear the counter and lp_busy, clear ovf and unf, and empty the stack.
REQ-046 Reset asserted mid-call or mid-loop SHALL abandon all state at once, with no dependence on clk.

Verification
REQ-047 Check: flags=0x40, md=0x06 -> cc=1; md=0x0E -> cc=0; md=0x08 -> cc=1 for every flags value.
REQ-048 Check: uaddr=0x012F, no control inputs -> next uaddr=0x0120 (no carry out of the nibble).
REQ-049 Check: nested calls from 0x0013 and 0x0205 (STKD=4), then two ret -> uaddr 0x0206 then 0x0014, stk_lvl 2->1->0.
REQ-050 Check: five calls with STKD=4 -> ovf=1 and stk_lvl=4; a ret at stk_lvl=0 -> unf=1 and uaddr advances by one.
REQ-051 Check: lp_ld with lp_cnt=3 at 0x0040, lp_end at 0x0042 -> the body 0x0041-0x0042 runs three times, then uaddr=0x0043 and lp_busy=0.
REQ-052 Check: still held high for 5 cycles during ni -> uaddr frozen; after still drops, uaddr={nxgr,md,0}; rst pulse mid-loop -> uaddr=RST_UA and lp_busy=0 immediately.

Source files
------------

// File: rtl/jt900h_useq.sv
// Microcode sequencer: sequential microaddress stepping, microsubroutine calls
// with a small return stack, counted inner loops and opcode dispatch.
module jt900h_useq #(
  parameter int              UAW    = 14,
  parameter int              OPW    = 8,
  parameter int              STKD   = 4,
  parameter int              LCW    = 8,
  parameter logic [UAW-1:0]  RST_UA = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cen,
  input  logic                      still,
  input  logic [OPW-1:0]            md,
  input  logic [7:0]                flags,
  input  logic                      zu,
  input  logic                      ni,
  input  logic [1:0]                nxgr,
  input  logic                      jsr_en,
  input  logic [1:0]                jsr_cnd,
  input  logic [UAW-1:0]            jsr_ua,
  input  logic                      ret,
  input  logic                      lp_ld,
  input  logic [LCW-1:0]            lp_cnt,
  input  logic                      lp_end,
  output logic [UAW-1:0]            uaddr,
  output logic                      cc,
  output logic [$clog2(STKD):0]     stk_lvl,
  output logic                      lp_busy,
  output logic                      ovf,
  output logic                      unf
);

  localparam int SLW = $clog2(STKD) + 1;
  localparam int SIW = SLW - 1;

  logic [UAW-1:0] stk [STKD];
  logic [LCW-1:0] lp_ctr, ctr_nx;
  logic [3:0]     lp_start, start_nx;
  logic [UAW-1:0] ua_nx, seq_ua, ni_ua;
  logic [SLW-1:0] lvl_nx;
  logic           ovf_nx, unf_nx, push;
  logic           cc_base, cnd_ok, call_tk, stk_full;
  logic [SIW-1:0] top_idx;

  wire s_f = flags[7];
  wire z_f = flags[6];
  wire v_f = flags[2];
  wire c_f = flags[0];

  // Codes 8..15 are the complements of 0..7, so md[3] simply inverts.
  always_comb begin
    cc_base = 1'b0;
    case (md[2:0])
      3'd0: cc_base = 1'b0;
      3'd1: cc_base = s_f ^ v_f;
      3'd2: cc_base = z_f | (s_f ^ v_f);
      3'd3: cc_base = z_f | c_f;
      3'd4: cc_base = v_f;
      3'd5: cc_base = s_f;
      3'd6: cc_base = z_f;
      3'd7: cc_base = c_f;
      default: cc_base = 1'b0;
    endcase
    cc = cc_base ^ md[3];
  end

  always_comb begin
    cnd_ok = 1'b1;
    case (jsr_cnd)
      2'd0: cnd_ok = 1'b1;
      2'd1: cnd_ok = cc;
      2'd2: cnd_ok = ~cc;
      2'd3: cnd_ok = ~zu;
      default: cnd_ok = 1'b1;
    endcase
  end

  assign call_tk  = jsr_en & cnd_ok;
  assign stk_full = (stk_lvl == SLW'(STKD));
  assign top_idx  = stk_lvl[SIW-1:0] - SIW'(1);
  assign seq_ua   = {uaddr[UAW-1:4], uaddr[3:0] + 4'd1};
  assign ni_ua    = UAW'({nxgr, md, 4'd0});
  assign lp_busy  = (lp_ctr != '0);

  // Priority: call (or tail call) > ret > loop-back > dispatch > sequential.
  // A loop load is applied on top of whichever event wins.
  always_comb begin
    ua_nx    = seq_ua;
    lvl_nx   = stk_lvl;
    ctr_nx   = lp_ctr;
    start_nx = lp_start;
    ovf_nx   = ovf;
    unf_nx   = unf;
    push     = 1'b0;
    if (call_tk) begin
      ua_nx = jsr_ua;
      if (!ret) begin
        if (stk_full) begin
          ovf_nx = 1'b1;
        end else begin
          push   = 1'b1;
          lvl_nx = stk_lvl + SLW'(1);
        end
      end
    end else if (ret) begin
      if (stk_lvl != '0) begin
        ua_nx  = stk[top_idx];
        lvl_nx = stk_lvl - SLW'(1);
      end else begin
        unf_nx = 1'b1;
      end
    end else if (lp_end && (lp_ctr > LCW'(1))) begin
      ctr_nx = lp_ctr - LCW'(1);
      ua_nx  = {uaddr[UAW-1:4], lp_start};
    end else begin
      if (lp_end) ctr_nx = '0;
      if (ni) begin
        ua_nx  = ni_ua;
        ctr_nx = '0;
      end
    end
    if (lp_ld) begin
      ctr_nx   = lp_cnt;
      start_nx = uaddr[3:0] + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uaddr    <= RST_UA;
      stk_lvl  <= '0;
      lp_ctr   <= '0;
      lp_start <= '0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      for (int i = 0; i < STKD; i++) stk[i] <= '0;
    end else if (cen && !still) begin
      uaddr    <= ua_nx;
      stk_lvl  <= lvl_nx;
      lp_ctr   <= ctr_nx;
      lp_start <= start_nx;
      ovf      <= ovf_nx;
      unf      <= unf_nx;
      if (push) stk[stk_lvl[SIW-1:0]] <= seq_ua;
    end
  end

endmodule
